// File: rtl/bus_sel_pkg.sv
// Shared mode encodings and pointer helper for the N-channel bus selector.
// No logic of its own; no latency or backpressure involvement.
// Imported by the arbiter and the top level.
package bus_sel_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Explicit wrap keeps non-power-of-2 channel counts correct.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n_ch);
        return (idx + 32'd1 >= n_ch) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority request search starting at ptr, wrapping modulo N_CH.
// Purely combinational, zero latency.
// No backpressure; the caller qualifies the grant with its own load enable.
module rr_arbiter
    import bus_sel_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] grant_idx,
    output logic            grant_vld
);

    always_comb begin
        int unsigned idx;
        idx       = 32'd0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!grant_vld && req[CH_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_sel_arb.sv
// Registered N-channel bus selector, fixed-select or round-robin source choice.
// Latency 1 cycle from input handshake to out_valid; full throughput.
// Backpressure: in_ready drops to all-zero while the held word is not consumed.
module bus_sel_arb
    import bus_sel_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4,
    parameter int CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [CH_W-1:0]       sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int SEL_SPAN = 1 << CH_W;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [CH_W-1:0]  ch;
    } out_t;

    logic [WIDTH-1:0]    ch_dat [N_CH];
    out_t                out_q, out_d;
    logic                out_vld_q, out_vld_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]     rr_idx;
    logic                rr_vld;
    logic [SEL_SPAN-1:0] valid_pad;
    logic [SEL_SPAN-1:0] ready_pad;
    logic [CH_W-1:0]     grant;
    logic                grant_vld;
    logic                can_load;
    logic                xfer;

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_dat[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

    // Padding to the full index span makes an out-of-range sel land on a zero bit.
    always_comb begin
        valid_pad = SEL_SPAN'(in_valid);
        can_load  = !out_vld_q || out_ready;
        if (mode == MODE_RR) begin
            grant     = rr_idx;
            grant_vld = rr_vld;
        end else begin
            grant     = sel;
            grant_vld = valid_pad[sel];
        end
        xfer = grant_vld && can_load;
    end

    // Fixed mode offers ready on sel even when that channel has nothing valid.
    always_comb begin
        ready_pad = '0;
        if (mode == MODE_RR) begin
            ready_pad[grant] = rr_vld && can_load;
        end else begin
            ready_pad[grant] = can_load;
        end
    end

    assign in_ready = rst_n ? ready_pad[N_CH-1:0] : '0;

    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q && !out_ready;
        rr_ptr_d  = rr_ptr_q;
        if (xfer) begin
            out_d.dat = ch_dat[grant];
            out_d.ch  = grant;
            out_vld_d = 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr_d = CH_W'(next_ptr(32'(grant), N_CH));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign out_data  = out_q.dat;
    assign out_ch    = out_q.ch;
    assign out_valid = out_vld_q;

endmodule

// File: tb/tb_bus_sel_arb.sv
// Directed bench for bus_sel_arb with WIDTH=4, N_CH=4.
module tb_bus_sel_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_sel_arb #(
        .WIDTH (4),
        .N_CH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = 16'h0000;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_ch",    32'(out_ch),    32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Fixed select onto channel 2
        sel       = 2'd2;
        in_data   = 16'h0A00;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        check("fix_rdy", 32'(in_ready), 32'h4);
        tick();
        check("fix_data",  32'(out_data),  32'hA);
        check("fix_ch",    32'(out_ch),    32'd2);
        check("fix_valid", 32'(out_valid), 32'd1);

        // sel on an idle channel: ready offered there, but nothing moves
        sel = 2'd1;
        #1;
        check("fix_idle_rdy", 32'(in_ready), 32'h2);
        tick();
        check("fix_idle_valid", 32'(out_valid), 32'd0);
        check("fix_idle_data",  32'(out_data),  32'hA);
        check("fix_idle_ch",    32'(out_ch),    32'd2);

        // Backpressure
        sel       = 2'd2;
        in_valid  = 4'b1111;
        in_data   = 16'h0A00;
        out_ready = 1'b0;
        #1;
        check("bp_load_rdy", 32'(in_ready), 32'h4);
        tick();
        check("bp_load_valid", 32'(out_valid), 32'd1);
        check("bp_load_data",  32'(out_data),  32'hA);
        in_data = 16'h0500;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'h0);
            tick();
            check($sformatf("bp_data%0d", i),  32'(out_data),  32'hA);
            check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'h4);
        tick();
        check("bp_release_data", 32'(out_data), 32'h5);
        check("bp_release_ch",   32'(out_ch),   32'd2);

        // Round-robin fairness, pointer starts at 0
        mode     = 1'b1;
        in_data  = 16'h4321;
        in_valid = 4'b1111;
        #1;
        check("rr_first_rdy", 32'(in_ready), 32'h1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("rr_ch%0d", i),   32'(out_ch),   32'(i % 4));
            check($sformatf("rr_data%0d", i), 32'(out_data), 32'(i % 4 + 1));
        end

        // Pointer now 3: only channel 1 requesting wraps past 3 and 0
        in_valid = 4'b0010;
        #1;
        check("skip_rdy", 32'(in_ready), 32'h2);
        tick();
        check("skip_ch",   32'(out_ch),   32'd1);
        check("skip_data", 32'(out_data), 32'h2);
        in_valid = 4'b0000;
        #1;
        check("idle_rdy", 32'(in_ready), 32'h0);
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_ch",    32'(out_ch),    32'd1);
        check("idle_data",  32'(out_data),  32'h2);
        tick();
        check("idle_valid2", 32'(out_valid), 32'd0);

        // Pointer held at 2 through the idle cycles
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("resume_ch%0d", i), 32'(out_ch), 32'((i + 2) % 4));
        end

        // Fixed-mode detour must not disturb the round-robin pointer (now 2)
        mode = 1'b0;
        sel  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sw_fix_ch%0d", i),   32'(out_ch),   32'd0);
            check($sformatf("sw_fix_data%0d", i), 32'(out_data), 32'h1);
        end
        mode = 1'b1;
        tick();
        check("sw_rr_ch",   32'(out_ch),   32'd2);
        check("sw_rr_data", 32'(out_data), 32'h3);

        // Asynchronous reset while a word is held
        out_ready = 1'b0;
        tick();
        check("hold_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data",  32'(out_data),  32'd0);
        check("arst_ch",    32'(out_ch),    32'd0);
        check("arst_rdy",   32'(in_ready),  32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_rdy", 32'(in_ready), 32'h1);
        tick();
        check("post_rst_ch",   32'(out_ch),   32'd0);
        check("post_rst_data", 32'(out_data), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
